// File: rtl/axis2axi_in_if.sv
// Signal bundle for axis2axi_in: configuration, input stream, status and the
// AXI4 write-address, write-data and write-response channels.
interface axis2axi_in_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1
);
  logic [AXI_ADDR_W-1:0]   config_addr;
  logic [AXI_ADDR_W-1:0]   config_length;
  logic                    config_valid;
  logic                    config_ready;

  logic [AXI_DATA_W-1:0]   axis_data;
  logic                    axis_valid;
  logic                    axis_ready;

  logic                    busy;
  logic                    error;

  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [AXI_LEN_W-1:0]    awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [1:0]              awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    input  config_addr, config_length, config_valid,
    output config_ready,
    input  axis_data, axis_valid,
    output axis_ready,
    output busy, error,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    output config_addr, config_length, config_valid,
    input  config_ready,
    output axis_data, axis_valid,
    input  axis_ready,
    input  busy, error,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axis2axi_in.sv
// Stream-to-AXI4 write bridge: buffers stream words in a small FIFO and writes
// them out as incrementing bursts that never cross a 4 KB boundary.
module axis2axi_in #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ID_W   = 1,
  parameter int BURST_W    = 3
) (
  input  logic          clk_i,
  input  logic          cke_i,
  input  logic          arst_i,
  axis2axi_in_if.master bus
);
  localparam int BURST_SIZE = 1 << BURST_W;
  localparam int DEPTH      = 2 * BURST_SIZE;
  localparam int PTR_W      = BURST_W + 1;
  localparam int LVL_W      = BURST_W + 2;
  localparam logic [AXI_ADDR_W-1:0] BURST_MAX = AXI_ADDR_W'(BURST_SIZE);

  typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, RESP} state_t;

  state_t                  state, state_next;
  logic [AXI_DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]        level;
  logic [AXI_ADDR_W-1:0]   addr, tx_remaining, rx_remaining;
  logic [AXI_LEN_W-1:0]    awlen_q, beat;
  logic                    error_q;
  logic [AXI_ADDR_W-1:0]   page_words, burst_size, burst_words;
  logic                    push, pop, last_beat;
  logic                    unused_bid;

  assign unused_bid  = ^bus.bid;
  assign push        = bus.axis_valid && bus.axis_ready;
  assign pop         = (state == DATA) && bus.wready;
  assign last_beat   = (beat == awlen_q);
  assign burst_words = AXI_ADDR_W'(awlen_q) + AXI_ADDR_W'(1);

  // Words left before the next 4 KB page; narrow address spaces have no page limit.
  generate
    if (AXI_ADDR_W >= 13) begin : g_page
      assign page_words = AXI_ADDR_W'(11'h400 - {1'b0, addr[11:2]});
    end else begin : g_no_page
      assign page_words = BURST_MAX;
    end
  endgenerate

  always_comb begin
    burst_size = tx_remaining;
    if (burst_size > BURST_MAX)  burst_size = BURST_MAX;
    if (burst_size > page_words) burst_size = page_words;
  end

  assign bus.axis_ready = (rx_remaining != '0) && (level != LVL_W'(DEPTH));
  assign bus.busy       = (state != IDLE);
  assign bus.error      = error_q;
  assign bus.awaddr     = addr;
  assign bus.awlen      = awlen_q;
  assign bus.awid       = '0;
  assign bus.awsize     = 3'd2;
  assign bus.awburst    = 2'd1;
  assign bus.awlock     = 2'd0;
  assign bus.awcache    = 4'd2;
  assign bus.awprot     = 3'd2;
  assign bus.awqos      = 4'd0;
  assign bus.wdata      = mem[rd_ptr];
  assign bus.wstrb      = '1;
  assign bus.wlast      = (state == DATA) && last_beat;

  always_comb begin
    state_next       = state;
    bus.config_ready = 1'b0;
    bus.awvalid      = 1'b0;
    bus.wvalid       = 1'b0;
    bus.bready       = 1'b0;
    case (state)
      IDLE: begin
        bus.config_ready = 1'b1;
        if (bus.config_valid && (bus.config_length != '0)) state_next = CALC;
      end
      CALC: if (AXI_ADDR_W'(level) >= burst_size) state_next = ADDR;
      ADDR: begin
        bus.awvalid = 1'b1;
        if (bus.awready) state_next = DATA;
      end
      DATA: begin
        bus.wvalid = 1'b1;
        if (bus.wready && last_beat) state_next = RESP;
      end
      RESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) state_next = (tx_remaining == burst_words) ? IDLE : CALC;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     state <= IDLE;
    else if (cke_i) state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (cke_i && push) mem[wr_ptr] <= bus.axis_data;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (cke_i) begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      level <= level + LVL_W'(1);
      else if (pop && !push) level <= level - LVL_W'(1);
    end
  end

  // Receive and transmit counts are tracked separately so the stream can run ahead of AXI.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      addr         <= '0;
      tx_remaining <= '0;
      rx_remaining <= '0;
      awlen_q      <= '0;
      beat         <= '0;
      error_q      <= 1'b0;
    end else if (cke_i) begin
      if (push) rx_remaining <= rx_remaining - AXI_ADDR_W'(1);
      case (state)
        IDLE: if (bus.config_valid) begin
          addr         <= bus.config_addr;
          tx_remaining <= bus.config_length;
          rx_remaining <= bus.config_length;
          error_q      <= 1'b0;
        end
        CALC: awlen_q <= AXI_LEN_W'(burst_size - AXI_ADDR_W'(1));
        ADDR: beat <= '0;
        DATA: if (bus.wready) beat <= beat + AXI_LEN_W'(1);
        RESP: if (bus.bvalid) begin
          addr         <= addr + (burst_words << 2);
          tx_remaining <= tx_remaining - burst_words;
          if (bus.bresp != 2'b00) error_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_axis2axi_in.sv
// Randomized bench for axis2axi_in: a burst-planning scoreboard predicts every
// AXI beat and handshake-ready signal, with literal expectations for fixed cases.
module tb_axis2axi_in;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LW    = 8;
  localparam int IW    = 1;
  localparam int BW    = 3;
  localparam int BURST = 8;
  localparam int DEPTH = 16;

  typedef struct {
    logic [31:0] addr;
    int          len;
  } burst_t;

  logic clk_i  = 1'b0;
  logic cke_i  = 1'b1;
  logic arst_i = 1'b0;

  axis2axi_in_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW)) bus ();

  axis2axi_in #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW), .BURST_W(BW)) dut (
    .clk_i (clk_i),
    .cke_i (cke_i),
    .arst_i(arst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  burst_t      plan_q[$];
  logic [31:0] data_q[$];
  logic [31:0] aw_addr_log[$];
  int          aw_len_log[$];
  logic [31:0] w_log[$];
  int          wlast_log[$];
  int          rx_left, level, phase, beat, b_count;
  bit          m_busy, m_err;
  bit          cfg_fire, axis_fire, aw_fire, w_fire, b_fire;
  int          aw_pct = 100, w_pct = 100, b_pct = 100, err_burst = -1;
  bit          abort = 1'b0;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Splits a transfer into bursts: at most BURST words, never past a 4 KB page.
  function automatic void plan_bursts(input logic [31:0] a, input int n);
    burst_t b;
    int     words, page;
    while (n > 0) begin
      words = (n < BURST) ? n : BURST;
      page  = (4096 - int'(a[11:0])) / 4;
      if (words > page) words = page;
      b.addr = a;
      b.len  = words;
      plan_q.push_back(b);
      a = a + 32'(words * 4);
      n = n - words;
    end
  endfunction

  function automatic void model_clear();
    plan_q.delete();
    data_q.delete();
    rx_left = 0; level = 0; phase = 0; beat = 0; b_count = 0;
    m_busy = 1'b0; m_err = 1'b0;
    cfg_fire = 1'b0; axis_fire = 1'b0; aw_fire = 1'b0; w_fire = 1'b0; b_fire = 1'b0;
  endfunction

  // Scoreboard: check outputs against the model, then advance it by the
  // handshakes that will complete on the next rising edge.
  always @(negedge clk_i) begin
    if (arst_i) begin
      model_clear();
    end else begin
      cfg_fire  = bus.config_valid && bus.config_ready;
      axis_fire = bus.axis_valid && bus.axis_ready;
      aw_fire   = bus.awvalid && bus.awready;
      w_fire    = bus.wvalid && bus.wready;
      b_fire    = bus.bvalid && bus.bready;

      check_output("busy", bus.busy, m_busy);
      check_output("config_ready", bus.config_ready, !m_busy);
      check_output("error", bus.error, m_err);
      check_output("axis_ready", bus.axis_ready, (rx_left != 0) && (level != DEPTH));
      check_output("bready", bus.bready, phase == 2);
      if (bus.awvalid) begin
        check_output("aw_phase", phase, 0);
        check_output("aw_planned", plan_q.size() != 0, 1);
        if (plan_q.size() != 0) begin
          check_output("awaddr", bus.awaddr, plan_q[0].addr);
          check_output("awlen", bus.awlen, plan_q[0].len - 1);
          check_output("aw_data_buffered", level >= plan_q[0].len, 1);
        end
      end
      if (bus.wvalid) begin
        check_output("w_phase", phase, 1);
        if (data_q.size() != 0) check_output("wdata", bus.wdata, data_q[0]);
        if (plan_q.size() != 0) check_output("wlast", bus.wlast, beat == plan_q[0].len - 1);
      end else begin
        check_output("wlast_idle", bus.wlast, 0);
      end

      if (cfg_fire) begin
        plan_q.delete();
        plan_bursts(bus.config_addr, int'(bus.config_length));
        rx_left = int'(bus.config_length);
        m_err   = 1'b0;
        m_busy  = (bus.config_length != 0);
        b_count = 0;
        aw_addr_log.delete(); aw_len_log.delete(); w_log.delete(); wlast_log.delete();
      end
      if (axis_fire) begin
        data_q.push_back(bus.axis_data);
        rx_left--;
        level++;
      end
      if (aw_fire) begin
        phase = 1;
        beat  = 0;
        aw_addr_log.push_back(bus.awaddr);
        aw_len_log.push_back(int'(bus.awlen));
      end
      if (w_fire) begin
        w_log.push_back(bus.wdata);
        if (bus.wlast) wlast_log.push_back(w_log.size());
        if (data_q.size() != 0) void'(data_q.pop_front());
        level--;
        if (plan_q.size() != 0 && beat == plan_q[0].len - 1) phase = 2;
        beat++;
      end
      if (b_fire) begin
        if (bus.bresp != 2'b00) m_err = 1'b1;
        if (plan_q.size() != 0) void'(plan_q.pop_front());
        phase = 0;
        b_count++;
        if (plan_q.size() == 0) m_busy = 1'b0;
      end
    end
  end

  // AXI slave: random AW/W backpressure, write response once all beats are in.
  initial begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    bus.bid     = '0;
    forever begin
      @(posedge clk_i); #1;
      bus.awready = ($urandom_range(0, 99) < aw_pct);
      bus.wready  = ($urandom_range(0, 99) < w_pct);
      if (arst_i || phase != 2) begin
        bus.bvalid = 1'b0;
      end else if (!bus.bvalid && ($urandom_range(0, 99) < b_pct)) begin
        bus.bvalid = 1'b1;
        bus.bresp  = (b_count == err_burst) ? 2'b10 : 2'b00;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got 0x0, expected 0x1");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic send_config(input logic [31:0] addr, input int len);
    int guard = 0;
    bus.config_addr   = addr;
    bus.config_length = 32'(len);
    bus.config_valid  = 1'b1;
    do begin
      @(posedge clk_i); #1;
      guard++;
    end while (!cfg_fire && guard < 200);
    check_output("config_accepted", cfg_fire, 1);
    bus.config_valid = 1'b0;
  endtask

  task automatic send_stream(input int len, input int gap_pct, input bit seq);
    int sent = 0, guard = 0;
    while (sent < len && !abort && guard < 4000) begin
      if (!bus.axis_valid && ($urandom_range(0, 99) >= gap_pct)) begin
        bus.axis_valid = 1'b1;
        bus.axis_data  = seq ? 32'(sent + 1) : $urandom;
      end
      @(posedge clk_i); #1;
      guard++;
      if (axis_fire) begin
        sent++;
        bus.axis_valid = 1'b0;
      end
    end
    bus.axis_valid = 1'b0;
    if (!abort) check_output("stream_all_sent", sent, len);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((m_busy || bus.busy) && guard < 4000) begin
      @(posedge clk_i); #1;
      guard++;
    end
    check_output("transfer_done", bus.busy, 0);
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input int len, input int gap_pct, input bit seq);
    send_config(addr, len);
    send_stream(len, gap_pct, seq);
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    check_output("rst_config_ready", bus.config_ready, 1);
    check_output("rst_awvalid", bus.awvalid, 0);
    check_output("rst_wvalid", bus.wvalid, 0);
    check_output("rst_wlast", bus.wlast, 0);
    check_output("rst_bready", bus.bready, 0);
    check_output("rst_axis_ready", bus.axis_ready, 0);
    check_output("rst_busy", bus.busy, 0);
    check_output("rst_error", bus.error, 0);
    check_output("rst_awaddr", bus.awaddr, 0);
    check_output("rst_awlen", bus.awlen, 0);
  endtask

  task automatic check_aw(input int idx, input logic [31:0] addr, input int len);
    check_output("aw_log_present", aw_addr_log.size() > idx, 1);
    if (aw_addr_log.size() > idx) begin
      check_output("aw_log_addr", aw_addr_log[idx], addr);
      check_output("aw_log_len", aw_len_log[idx], len);
    end
  endtask

  task automatic check_seq_data(input int n);
    check_output("w_log_count", w_log.size(), n);
    for (int i = 0; i < n && i < w_log.size(); i++) check_output("w_log_data", w_log[i], i + 1);
  endtask

  initial begin
    logic [31:0] a;
    bus.config_addr   = '0;
    bus.config_length = '0;
    bus.config_valid  = 1'b0;
    bus.axis_data     = '0;
    bus.axis_valid    = 1'b0;

    #1 arst_i = 1'b1;
    #1;
    check_reset_outputs();
    check_output("const_awsize", bus.awsize, 2);
    check_output("const_awburst", bus.awburst, 1);
    check_output("const_awcache", bus.awcache, 2);
    check_output("const_awprot", bus.awprot, 2);
    check_output("const_awlock", bus.awlock, 0);
    check_output("const_awqos", bus.awqos, 0);
    check_output("const_awid", bus.awid, 0);
    check_output("const_wstrb", bus.wstrb, 4'hf);
    repeat (2) @(posedge clk_i);
    #1 arst_i = 1'b0;

    $display("[TB] single 8-word burst at 0x100");
    apply_stimulus(32'h100, 8, 0, 1'b1);
    check_output("b2b_aw_count", aw_addr_log.size(), 1);
    check_aw(0, 32'h100, 7);
    check_seq_data(8);
    check_output("b2b_wlast_count", wlast_log.size(), 1);
    if (wlast_log.size() != 0) check_output("b2b_wlast_beat", wlast_log[0], 8);

    $display("[TB] zero-length transfer");
    send_config(32'h40, 0);
    repeat (5) @(posedge clk_i);
    #1;
    check_output("len0_busy", bus.busy, 0);
    check_output("len0_axis_ready", bus.axis_ready, 0);
    check_output("len0_no_aw", aw_addr_log.size(), 0);

    $display("[TB] 4 KB boundary split at 0xFF8");
    apply_stimulus(32'hff8, 8, 0, 1'b0);
    check_output("split_aw_count", aw_addr_log.size(), 2);
    check_aw(0, 32'hff8, 1);
    check_aw(1, 32'h1000, 5);

    $display("[TB] sparse stream with AXI stalls");
    aw_pct = 50; w_pct = 50; b_pct = 50;
    apply_stimulus(32'h0, 20, 60, 1'b1);
    check_output("stall_aw_count", aw_addr_log.size(), 3);
    check_aw(0, 32'h0, 7);
    check_aw(1, 32'h20, 7);
    check_aw(2, 32'h40, 3);
    check_seq_data(20);

    $display("[TB] error response on second burst");
    err_burst = 1;
    apply_stimulus(32'h0, 20, 20, 1'b0);
    check_output("err_sticky_idle", bus.error, 1);
    err_burst = -1;
    send_config(32'h80, 4);
    check_output("err_cleared_on_config", bus.error, 0);
    send_stream(4, 0, 1'b0);
    wait_idle();

    $display("[TB] randomized transfers");
    for (int t = 0; t < 8; t++) begin
      aw_pct = $urandom_range(30, 100);
      w_pct  = $urandom_range(30, 100);
      b_pct  = $urandom_range(30, 100);
      err_burst = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      if (t % 2 == 0) a = 32'h1000 * $urandom_range(1, 8) - 32'(4 * $urandom_range(0, 12));
      else            a = {18'd0, 12'($urandom_range(0, 4095)), 2'b00};
      apply_stimulus(a, $urandom_range(1, 40), $urandom_range(0, 70), 1'b0);
    end
    err_burst = -1;
    aw_pct = 100; w_pct = 100; b_pct = 100;

    $display("[TB] reset during data phase");
    fork
      begin
        send_config(32'h200, 16);
        send_stream(16, 0, 1'b1);
      end
      begin
        int g = 0;
        while (!bus.wvalid && g < 500) begin
          @(negedge clk_i);
          g++;
        end
        check_output("reached_data_phase", bus.wvalid, 1);
        #2;
        arst_i = 1'b1;
        abort  = 1'b1;
      end
    join
    bus.axis_valid = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk_i);
    #1;
    arst_i = 1'b0;
    abort  = 1'b0;
    apply_stimulus(32'h300, 5, 0, 1'b1);
    check_output("post_rst_aw_count", aw_addr_log.size(), 1);
    check_aw(0, 32'h300, 4);
    check_seq_data(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
